switch_bounce_gen: RTL and testbench

- Synthesisable bouncing-switch emulator that drives the `raw` input of the debouncer `top`.
- Takes a clean level request and produces a contact-bounce burst on `raw`, then settles at the requested level.
- Burst content comes from an LFSR, so stimulus is deterministic and repeatable.
- Used in benches and on-board self-test to exercise the debouncer without a physical switch.

---
 rtl/switch_bounce_pkg.sv | 13 +
 rtl/bounce_lfsr.sv | 38 +++
 rtl/switch_bounce_gen.sv | 115 +++++++++++
 tb/tb_switch_bounce_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/switch_bounce_pkg.sv
// Shared types and constants for the bouncing-switch emulator.
package switch_bounce_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } state_e;

    // Feedback taps at bits 15, 13, 12 and 10 of the 16-bit LFSR.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/bounce_lfsr.sv
// Fibonacci LFSR with advance enable, synchronous load and async active-low reset.
module bounce_lfsr
    import switch_bounce_pkg::*;
#(
    parameter int               LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED  = LFSR_W'(DEFAULT_SEED)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic              fb
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // fb is also bit 0 of the value the register takes when it advances.
    assign fb = ^(lfsr_q & TAPS);

    always_comb begin
        lfsr_d = lfsr_q;
        if (load)
            lfsr_d = load_val;
        else if (en)
            lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            lfsr_q <= SEED;
        else
            lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/switch_bounce_gen.sv
// Bouncing-switch emulator: LFSR-driven bounce burst on raw, then settles at target.
// Optional BOUNCE_SEED_LOAD_EN adds seed_load/seed_in to reseed the LFSR while idle.
module switch_bounce_gen
    import switch_bounce_pkg::*;
#(
    parameter int                CNT_W      = 8,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(DEFAULT_SEED),
    parameter logic              INIT_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic             target,
    input  logic [CNT_W-1:0] bounce_len,
`ifdef BOUNCE_SEED_LOAD_EN
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
`endif
    output logic             raw,
    output logic             busy,
    output logic             done
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_dec;
    logic              raw_q, raw_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tgt_q, tgt_d;
    logic              lfsr_en, lfsr_ld, lfsr_fb;
    logic [LFSR_W-1:0] lfsr_ld_val;

    bounce_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .en       (lfsr_en),
        .load     (lfsr_ld),
        .load_val (lfsr_ld_val),
        .fb       (lfsr_fb)
    );

    assign cnt_dec = cnt_q - 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        raw_d       = raw_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tgt_d       = tgt_q;
        lfsr_en     = 1'b0;
        lfsr_ld     = 1'b0;
        lfsr_ld_val = SEED;
        case (state_q)
            IDLE: begin
                if (req) begin
                    tgt_d = target;
                    if (target == raw_q || bounce_len == '0) begin
                        raw_d  = target;
                        done_d = 1'b1;
                    end else begin
                        // The first edge is always the genuine transition.
                        raw_d   = target;
                        busy_d  = 1'b1;
                        cnt_d   = bounce_len;
                        state_d = BOUNCE;
                    end
                end
`ifdef BOUNCE_SEED_LOAD_EN
                else if (seed_load) begin
                    lfsr_ld     = 1'b1;
                    lfsr_ld_val = (seed_in == '0) ? SEED : seed_in;
                end
`endif
            end
            BOUNCE: begin
                lfsr_en = 1'b1;
                cnt_d   = cnt_dec;
                if (cnt_dec != '0) begin
                    raw_d = lfsr_fb;
                end else begin
                    raw_d   = tgt_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            raw_q   <= INIT_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tgt_q   <= INIT_LEVEL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raw_q   <= raw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tgt_q   <= tgt_d;
        end
    end

    assign raw  = raw_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench for switch_bounce_gen with hand-computed LFSR bounce patterns.
module tb_switch_bounce_gen;

    logic       clock;
    logic       reset;
    logic       req;
    logic       target;
    logic [7:0] bounce_len;
    logic       raw, busy, done;
`ifdef BOUNCE_SEED_LOAD_EN
    logic        seed_load;
    logic [15:0] seed_in;
`endif

    int n_chk = 0;
    int n_err = 0;

    // First four fed-back bits from seed 16'hACE1, worked out by hand.
    logic [3:0] seed_pat;

    switch_bounce_gen dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .target     (target),
        .bounce_len (bounce_len),
`ifdef BOUNCE_SEED_LOAD_EN
        .seed_load  (seed_load),
        .seed_in    (seed_in),
`endif
        .raw        (raw),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue a one-cycle request; returns just after the edge that samples it.
    task automatic issue(input logic tgt, input logic [7:0] len);
        req        = 1'b1;
        target     = tgt;
        bounce_len = len;
        tick();
        req = 1'b0;
    endtask

    // Five-cycle burst to level 1 starting from a freshly seeded LFSR.
    task automatic seed_burst(input string tag);
        issue(1'b1, 8'd5);
        chk({tag, "_raw_k1"}, raw, 1);
        chk({tag, "_busy_k1"}, busy, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("%s_raw_b%0d", tag, i), raw, seed_pat[3-i]);
            chk($sformatf("%s_busy_b%0d", tag, i), busy, 1);
            chk($sformatf("%s_done_b%0d", tag, i), done, 0);
        end
        tick();
        chk({tag, "_raw_end"}, raw, 1);
        chk({tag, "_done_end"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        tick();
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_raw_hold"}, raw, 1);
    endtask

    initial begin
        int ndone;
        int ncyc;
        bit seen_busy;
        seed_pat   = 4'b1110;
        reset      = 1'b0;
        req        = 1'b0;
        target     = 1'b0;
        bounce_len = 8'd0;
`ifdef BOUNCE_SEED_LOAD_EN
        seed_load  = 1'b0;
        seed_in    = 16'h0;
`endif
        #300;
        @(negedge clock) reset = 1'b1;
        #1;
        chk("rst_raw", raw, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        seed_burst("burst5");

        // target already equals raw: immediate done, no busy
        issue(1'b1, 8'd7);
        chk("same_done", done, 1);
        chk("same_raw", raw, 1);
        chk("same_busy", busy, 0);
        tick();
        chk("same_done_clr", done, 0);

        // zero-length burst
        issue(1'b0, 8'd0);
        chk("zero_raw", raw, 0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_done_clr", done, 0);

        // request during a 20-cycle burst is ignored
        issue(1'b1, 8'd20);
        chk("long_busy", busy, 1);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) begin
                req = 1'b1; target = 1'b0; bounce_len = 8'd3;
            end
            tick();
            req = 1'b0;
            if (done) ndone++;
            if (i == 5) chk("long_busy_mid", busy, 1);
        end
        chk("long_ndone", ndone, 1);
        chk("long_raw", raw, 1);
        chk("long_busy_end", busy, 0);

        // reset pulled low on the third bounce cycle of a 10-cycle burst
        issue(1'b0, 8'd10);
        tick(); tick(); tick();
        chk("abort_busy_pre", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_raw", raw, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_ndone", ndone, 0);
        @(negedge clock) reset = 1'b1;
        #1;
        // LFSR must be back at its seed
        seed_burst("reseed");

        // maximum length burst, no wrap: done exactly 255 edges after the request
        issue(1'b0, 8'd255);
        ncyc = 0;
        seen_busy = 1'b0;
        while (!done && ncyc < 300) begin
            tick();
            ncyc++;
            if (busy) seen_busy = 1'b1;
        end
        chk("max_cycles", ncyc, 255);
        chk("max_raw", raw, 0);
        chk("max_seen_busy", seen_busy, 1);
        chk("max_busy_end", busy, 0);
        tick();
        chk("max_done_clr", done, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
